// File: rtl/adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// adder_share_arbiter
//
// Purpose:
//   Shares a single A_W-bit + B_W-bit zero-extending adder between two
//   requesters. A round-robin arbiter picks at most one operand pair per cycle.
//   The (A_W+1)-bit sum, tagged with the requester id, is pushed into a small
//   result FIFO that drains over a valid/ready output port. The block sits
//   between the partial-product accumulation stages and the normalisation
//   stage of the multiplier datapath.
//
// Handshake semantics (all ports):
//   A transfer happens on a rising clk edge where valid and ready are both
//   high. A producer holding valid keeps its payload stable until that edge.
//   reqN_ready depends only on the request valids, the arbitration history and
//   the FIFO fill level, never on res_ready, so there is no combinational
//   path from the result consumer back to the requesters.
//
// Ports:
//   clk                    clock, rising edge
//   rst                    asynchronous, active-high reset
//   req0_valid/a/b/ready   requester 0 operand pair handshake
//   req1_valid/a/b/ready   requester 1 operand pair handshake
//   res_valid/sum/id/ready result FIFO head handshake
//   grant_cnt0/1           accepted-request counters (wrap modulo 2^CNT_W)
// -----------------------------------------------------------------------------
module adder_share_arbiter #(
  parameter int A_W   = 47,
  parameter int B_W   = 19,
  parameter int DEPTH = 2,
  parameter int CNT_W = 16
) (
  input  logic             clk,
  input  logic             rst,

  input  logic             req0_valid,
  input  logic [A_W-1:0]   req0_a,
  input  logic [B_W-1:0]   req0_b,
  output logic             req0_ready,

  input  logic             req1_valid,
  input  logic [A_W-1:0]   req1_a,
  input  logic [B_W-1:0]   req1_b,
  output logic             req1_ready,

  output logic             res_valid,
  output logic [A_W:0]     res_sum,
  output logic             res_id,
  input  logic             res_ready,

  output logic [CNT_W-1:0] grant_cnt0,
  output logic [CNT_W-1:0] grant_cnt1
);

  localparam int PTR_W = $clog2(DEPTH);
  localparam logic [PTR_W:0] DEPTH_C = (PTR_W + 1)'(DEPTH);

  // FIFO storage and bookkeeping
  logic [A_W:0]       sum_mem_q [DEPTH];
  logic [DEPTH-1:0]   id_mem_q;
  logic [PTR_W-1:0]   wr_ptr_q;
  logic [PTR_W-1:0]   rd_ptr_q;
  logic [PTR_W:0]     count_q;
  logic [PTR_W:0]     count_d;

  // Last popped head, presented while the FIFO is empty
  logic [A_W:0]       hold_sum_q;
  logic               hold_id_q;

  // Arbitration history: 1 after reset so requester 0 wins the first tie
  logic               last_served_q;

  logic [CNT_W-1:0]   cnt0_q;
  logic [CNT_W-1:0]   cnt1_q;

  logic               grant0;
  logic               grant1;
  logic               not_full;
  logic               push0;
  logic               push1;
  logic               push;
  logic               pop;
  logic [A_W-1:0]     push_a;
  logic [B_W-1:0]     push_b;
  logic [A_W:0]       push_sum;

  // Round robin: a lone valid always wins; on a tie the requester that was
  // not served last wins.
  assign grant0 = req0_valid & (~req1_valid |  last_served_q);
  assign grant1 = req1_valid & (~req0_valid | ~last_served_q);

  assign not_full   = (count_q < DEPTH_C);
  assign req0_ready = grant0 & not_full;
  assign req1_ready = grant1 & not_full;

  assign push0 = req0_valid & req0_ready;
  assign push1 = req1_valid & req1_ready;
  assign push  = push0 | push1;

  // The shared adder: operand B is zero-extended, carry-out kept in the MSB.
  assign push_a   = push1 ? req1_a : req0_a;
  assign push_b   = push1 ? req1_b : req0_b;
  assign push_sum = {1'b0, push_a} + {{(A_W + 1 - B_W){1'b0}}, push_b};

  assign res_valid = (count_q != '0);
  assign pop       = res_valid & res_ready;

  assign res_sum = res_valid ? sum_mem_q[rd_ptr_q] : hold_sum_q;
  assign res_id  = res_valid ? id_mem_q[rd_ptr_q]  : hold_id_q;

  assign grant_cnt0 = cnt0_q;
  assign grant_cnt1 = cnt1_q;

  // Push and pop in the same cycle leave the fill level unchanged.
  always_comb begin
    count_d = count_q;
    case ({push, pop})
      2'b10:   count_d = count_q + 1'b1;
      2'b01:   count_d = count_q - 1'b1;
      default: count_d = count_q;
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      for (int i = 0; i < DEPTH; i++) begin
        sum_mem_q[i] <= '0;
      end
      id_mem_q      <= '0;
      wr_ptr_q      <= '0;
      rd_ptr_q      <= '0;
      count_q       <= '0;
      hold_sum_q    <= '0;
      hold_id_q     <= 1'b0;
      last_served_q <= 1'b1;
      cnt0_q        <= '0;
      cnt1_q        <= '0;
    end else begin
      count_q <= count_d;
      if (push) begin
        sum_mem_q[wr_ptr_q] <= push_sum;
        id_mem_q[wr_ptr_q]  <= push1;
        wr_ptr_q            <= wr_ptr_q + 1'b1;
        last_served_q       <= push1;
        if (push0) cnt0_q <= cnt0_q + 1'b1;
        if (push1) cnt1_q <= cnt1_q + 1'b1;
      end
      if (pop) begin
        rd_ptr_q   <= rd_ptr_q + 1'b1;
        hold_sum_q <= sum_mem_q[rd_ptr_q];
        hold_id_q  <= id_mem_q[rd_ptr_q];
      end
    end
  end

endmodule

// File: tb/tb_adder_share_arbiter.sv
// -----------------------------------------------------------------------------
// tb_adder_share_arbiter
//
// Bench for adder_share_arbiter: a directed vector table, a randomized stream
// checked against a queue-based reference model, and a counter-wrap run on a
// second instance built with CNT_W=4.
// -----------------------------------------------------------------------------
module tb_adder_share_arbiter;

  localparam int AW    = 47;
  localparam int BW    = 19;
  localparam int DEPTH = 2;
  localparam logic [AW-1:0] MAX_A = 47'h7FFF_FFFF_FFFF;
  localparam logic [BW-1:0] MAX_B = 19'h7FFFF;

  // ---------------------------------------------------------------- clock/reset
  logic clk = 1'b0;
  logic rst = 1'b1;
  always #5 clk = ~clk;

  // ---------------------------------------------------------------- main DUT
  logic          req0_valid = 1'b0;
  logic [AW-1:0] req0_a     = '0;
  logic [BW-1:0] req0_b     = '0;
  logic          req0_ready;
  logic          req1_valid = 1'b0;
  logic [AW-1:0] req1_a     = '0;
  logic [BW-1:0] req1_b     = '0;
  logic          req1_ready;
  logic          res_valid;
  logic [AW:0]   res_sum;
  logic          res_id;
  logic          res_ready  = 1'b0;
  logic [15:0]   grant_cnt0;
  logic [15:0]   grant_cnt1;

  adder_share_arbiter u_dut (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (req0_valid),
    .req0_a     (req0_a),
    .req0_b     (req0_b),
    .req0_ready (req0_ready),
    .req1_valid (req1_valid),
    .req1_a     (req1_a),
    .req1_b     (req1_b),
    .req1_ready (req1_ready),
    .res_valid  (res_valid),
    .res_sum    (res_sum),
    .res_id     (res_id),
    .res_ready  (res_ready),
    .grant_cnt0 (grant_cnt0),
    .grant_cnt1 (grant_cnt1)
  );

  // ---------------------------------------------------------------- wrap DUT
  logic          w_v0 = 1'b0;
  logic          w_v1 = 1'b0;
  logic [AW-1:0] w_a  = 47'd3;
  logic [BW-1:0] w_b  = 19'd4;
  logic          w_rdy0;
  logic          w_rdy1;
  logic          w_rv;
  logic [AW:0]   w_sum;
  logic          w_id;
  logic          w_rr = 1'b1;
  logic [3:0]    w_cnt0;
  logic [3:0]    w_cnt1;

  adder_share_arbiter #(.CNT_W(4)) u_wrap (
    .clk        (clk),
    .rst        (rst),
    .req0_valid (w_v0),
    .req0_a     (w_a),
    .req0_b     (w_b),
    .req0_ready (w_rdy0),
    .req1_valid (w_v1),
    .req1_a     (w_a),
    .req1_b     (w_b),
    .req1_ready (w_rdy1),
    .res_valid  (w_rv),
    .res_sum    (w_sum),
    .res_id     (w_id),
    .res_ready  (w_rr),
    .grant_cnt0 (w_cnt0),
    .grant_cnt1 (w_cnt1)
  );

  // ---------------------------------------------------------------- scoreboard
  int n_tests = 0;
  int n_fail  = 0;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_tests++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h, expected 0x%0h (t=%0t)", name, act, exp, $time);
    end
  endtask

  // ---------------------------------------------------------------- vector table
  typedef struct {
    bit            r;
    bit            v0;
    logic [AW-1:0] a0;
    logic [BW-1:0] b0;
    bit            v1;
    logic [AW-1:0] a1;
    logic [BW-1:0] b1;
    bit            rr;
    bit            e_rdy0;
    bit            e_rdy1;
    bit            e_rv;
    logic [AW:0]   e_sum;
    bit            e_id;
    logic [15:0]   e_c0;
    logic [15:0]   e_c1;
  } vec_t;

  vec_t vecs[$];

  function automatic void add_vec(bit r, bit v0, logic [AW-1:0] a0, logic [BW-1:0] b0,
                                  bit v1, logic [AW-1:0] a1, logic [BW-1:0] b1, bit rr,
                                  bit e0, bit e1, bit ev, logic [AW:0] es, bit ei,
                                  logic [15:0] c0, logic [15:0] c1);
    vec_t v;
    v.r = r; v.v0 = v0; v.a0 = a0; v.b0 = b0; v.v1 = v1; v.a1 = a1; v.b1 = b1; v.rr = rr;
    v.e_rdy0 = e0; v.e_rdy1 = e1; v.e_rv = ev; v.e_sum = es; v.e_id = ei;
    v.e_c0 = c0; v.e_c1 = c1;
    vecs.push_back(v);
  endfunction

  function automatic void rst_vec();
    add_vec(1, 0, 0, 0, 0, 0, 0, 0,  0, 0, 0, 0, 0, 0, 0);
  endfunction

  function automatic void fill_table();
    // Single request at the carry boundary
    rst_vec();
    add_vec(0, 1, MAX_A, MAX_B, 0, 0, 0, 1,  1, 0, 0, 48'h0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1,          0, 0, 1, 48'h8000_0007_FFFE, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1,          0, 0, 0, 48'h8000_0007_FFFE, 0, 1, 0);
    // Contention: grants alternate 0,1,0,1,0,1
    rst_vec();
    add_vec(0, 1, 10, 1, 1, 20, 2, 1,  1, 0, 0, 0,  0, 0, 0);
    add_vec(0, 1, 10, 1, 1, 20, 2, 1,  0, 1, 1, 11, 0, 1, 0);
    add_vec(0, 1, 10, 1, 1, 20, 2, 1,  1, 0, 1, 22, 1, 1, 1);
    add_vec(0, 1, 10, 1, 1, 20, 2, 1,  0, 1, 1, 11, 0, 2, 1);
    add_vec(0, 1, 10, 1, 1, 20, 2, 1,  1, 0, 1, 22, 1, 2, 2);
    add_vec(0, 1, 10, 1, 1, 20, 2, 1,  0, 1, 1, 11, 0, 3, 2);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 1, 22, 1, 3, 3);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1,    0, 0, 0, 22, 1, 3, 3);
    // Backpressure: fill to DEPTH, then drain
    rst_vec();
    add_vec(0, 0, 0, 0, 1, 5, 5, 0,  0, 1, 0, 0,  0, 0, 0);
    add_vec(0, 0, 0, 0, 1, 5, 5, 0,  0, 1, 1, 10, 1, 0, 1);
    add_vec(0, 0, 0, 0, 1, 5, 5, 0,  0, 0, 1, 10, 1, 0, 2);
    add_vec(0, 0, 0, 0, 1, 5, 5, 0,  0, 0, 1, 10, 1, 0, 2);
    add_vec(0, 0, 0, 0, 1, 5, 5, 1,  0, 0, 1, 10, 1, 0, 2);
    add_vec(0, 0, 0, 0, 1, 5, 5, 1,  0, 1, 1, 10, 1, 0, 2);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 10, 1, 0, 3);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 0, 10, 1, 0, 3);
    // Reset mid-operation with a full FIFO, last served = requester 0
    rst_vec();
    add_vec(0, 1, 1, 2, 0, 0, 0, 0,  1, 0, 0, 0, 0, 0, 0);
    add_vec(0, 1, 1, 2, 0, 0, 0, 0,  1, 0, 1, 3, 0, 1, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 0,  0, 0, 1, 3, 0, 2, 0);
    rst_vec();
    add_vec(0, 1, 7, 0, 1, 9, 0, 1,  1, 0, 0, 0, 0, 0, 0);
    add_vec(0, 0, 0, 0, 0, 0, 0, 1,  0, 0, 1, 7, 0, 1, 0);
  endfunction

  // ---------------------------------------------------------------- random helpers
  function automatic logic [AW-1:0] rnd_a();
    logic [63:0] r;
    r = {$urandom, $urandom};
    case ($urandom_range(0, 5))
      0:       return MAX_A;
      1:       return '0;
      default: return r[AW-1:0];
    endcase
  endfunction

  function automatic logic [BW-1:0] rnd_b();
    logic [31:0] r;
    r = $urandom;
    case ($urandom_range(0, 5))
      0:       return MAX_B;
      1:       return '0;
      default: return r[BW-1:0];
    endcase
  endfunction

  // ---------------------------------------------------------------- watchdog
  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  // ---------------------------------------------------------------- main test
  logic [AW+1:0] exp_q[$];   // {id, sum} in FIFO order

  initial begin
    bit            p0v, p1v;
    logic [AW-1:0] p0a, p1a;
    logic [BW-1:0] p0b, p1b;
    bit            m_last;
    int            m_c0, m_c1;
    int            popped;
    int            acc;
    bit            g0, g1, e0, e1, full;
    logic [AW+1:0] head;

    fill_table();
    repeat (2) @(negedge clk);

    // Directed table: drive after the falling edge, check 1 time unit later.
    for (int i = 0; i < vecs.size(); i++) begin
      @(negedge clk);
      rst        = vecs[i].r;
      req0_valid = vecs[i].v0;
      req0_a     = vecs[i].a0;
      req0_b     = vecs[i].b0;
      req1_valid = vecs[i].v1;
      req1_a     = vecs[i].a1;
      req1_b     = vecs[i].b1;
      res_ready  = vecs[i].rr;
      #1;
      chk($sformatf("vec%0d rdy0", i), 64'(req0_ready), 64'(vecs[i].e_rdy0));
      chk($sformatf("vec%0d rdy1", i), 64'(req1_ready), 64'(vecs[i].e_rdy1));
      chk($sformatf("vec%0d res_valid", i), 64'(res_valid), 64'(vecs[i].e_rv));
      chk($sformatf("vec%0d res_sum", i), 64'(res_sum), 64'(vecs[i].e_sum));
      chk($sformatf("vec%0d res_id", i), 64'(res_id), 64'(vecs[i].e_id));
      chk($sformatf("vec%0d cnt0", i), 64'(grant_cnt0), 64'(vecs[i].e_c0));
      chk($sformatf("vec%0d cnt1", i), 64'(grant_cnt1), 64'(vecs[i].e_c1));
    end

    // Fresh start for the random stream
    @(negedge clk);
    rst = 1'b1; req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b0;
    @(negedge clk);
    rst = 1'b0;

    p0v = 0; p1v = 0; p0a = '0; p1a = '0; p0b = '0; p1b = '0;
    m_last = 1'b1; m_c0 = 0; m_c1 = 0; popped = 0;
    exp_q.delete();

    for (int cyc = 0; cyc < 4000 && popped < 100; cyc++) begin
      @(negedge clk);
      // A pending offer stays untouched until accepted.
      if (!p0v && $urandom_range(0, 2) != 0) begin p0v = 1; p0a = rnd_a(); p0b = rnd_b(); end
      if (!p1v && $urandom_range(0, 2) != 0) begin p1v = 1; p1a = rnd_a(); p1b = rnd_b(); end
      req0_valid = p0v; req0_a = p0a; req0_b = p0b;
      req1_valid = p1v; req1_a = p1a; req1_b = p1b;
      res_ready  = ($urandom_range(0, 3) != 0);
      #1;
      // Reference: who should get the adder this cycle
      full = (exp_q.size() >= DEPTH);
      g0 = p0v && (!p1v || m_last == 1'b1);
      g1 = p1v && (!p0v || m_last == 1'b0);
      e0 = g0 && !full;
      e1 = g1 && !full;
      chk("rnd rdy0", 64'(req0_ready), 64'(e0));
      chk("rnd rdy1", 64'(req1_ready), 64'(e1));
      chk("rnd res_valid", 64'(res_valid), 64'(exp_q.size() != 0));
      chk("rnd cnt0", 64'(grant_cnt0), 64'(m_c0 % 65536));
      chk("rnd cnt1", 64'(grant_cnt1), 64'(m_c1 % 65536));
      if (exp_q.size() != 0) begin
        head = exp_q[0];
        chk("rnd res_sum", 64'(res_sum), 64'(head[AW:0]));
        chk("rnd res_id", 64'(res_id), 64'(head[AW+1]));
        if (res_ready) begin
          void'(exp_q.pop_front());
          popped++;
        end
      end
      if (e0) begin
        exp_q.push_back({1'b0, 48'(p0a) + 48'(p0b)});
        m_last = 1'b0; m_c0++; p0v = 0;
      end
      if (e1) begin
        exp_q.push_back({1'b1, 48'(p1a) + 48'(p1b)});
        m_last = 1'b1; m_c1++; p1v = 0;
      end
    end
    chk("rnd results drained", 64'(popped >= 100), 64'(1));

    @(negedge clk);
    req0_valid = 1'b0; req1_valid = 1'b0; res_ready = 1'b1;

    // Counter wrap on the CNT_W=4 instance: 17 accepts from requester 1
    acc = 0;
    for (int c = 0; c < 100 && acc < 17; c++) begin
      @(negedge clk);
      w_v1 = 1'b1;
      #1;
      if (w_rdy1) acc++;
    end
    @(negedge clk);
    w_v1 = 1'b0;
    #1;
    chk("wrap accepts", 64'(acc), 64'(17));
    chk("wrap cnt1", 64'(w_cnt1), 64'(1));
    chk("wrap cnt0", 64'(w_cnt0), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
